// File: rtl/nim_pkg.sv
// Shared types and constants for the memory-word to decimal-digit sequencer.
package nim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DIV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DIV_STEPS = 32;
  localparam int RADIX     = 10;
  localparam int REG_COUNT = 32;

endpackage

// File: rtl/nim_div10.sv
// Iterative restoring divide-by-10: one quotient bit per step, MSB first.
module nim_div10
  import nim_pkg::*;
#(
  parameter int W = DIV_STEPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         restart,
  input  logic         step,
  output logic         finish,
  output logic [W-1:0] quot,
  output logic [3:0]   rem
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  v;
  logic [4:0]    r;
  logic [CW-1:0] cnt;
  logic [4:0]    shifted;
  logic          ge;

  // Remainder stays below 10, so the shifted partial remainder never exceeds 19.
  assign shifted = {r[3:0], v[W-1]};
  assign ge      = (shifted >= 5'(RADIX));
  assign finish  = step && (cnt == CW'(1));
  assign quot    = v;
  assign rem     = r[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      r   <= '0;
      cnt <= '0;
    end else if (load) begin
      v   <= load_val;
      r   <= '0;
      cnt <= CW'(W);
    end else if (restart) begin
      r   <= '0;
      cnt <= CW'(W);
    end else if (step && (cnt != '0)) begin
      v   <= {v[W-2:0], ge};
      r   <= ge ? (shifted - 5'(RADIX)) : shifted;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/nim_digit_splitter.sv
// Reads one memory word and writes its decimal digits, most significant first,
// into a block of consecutive registers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; range-checks dst_reg
// S_READ  | mem_read asserted, word captured into the divider
// S_DIV   | 32 divide-by-10 steps, remainder becomes the next digit
// S_WRITE | digit written to dst_reg + NUM_DIGITS-1-k
// S_DONE  | done pulse, ovf reports leftover quotient
module nim_digit_splitter
  import nim_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [4:0]        dst_reg,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  localparam int         KW       = $clog2(NUM_DIGITS + 1);
  localparam logic [4:0] LAST_OFS = 5'(NUM_DIGITS - 1);
  localparam logic [5:0] MAX_DST  = 6'(REG_COUNT - NUM_DIGITS);

  state_t            state;
  logic [4:0]        dst_q;
  logic [KW-1:0]     k;
  logic              div_finish;
  logic [DATA_W-1:0] div_quot;
  logic [3:0]        div_rem;
  logic              out_of_range;

  assign out_of_range = ({1'b0, dst_reg} > MAX_DST);

  nim_div10 #(.W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_READ),
    .load_val (mem_rdata),
    .restart  (state == S_WRITE),
    .step     (state == S_DIV),
    .finish   (div_finish),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Digit is only driven while the write strobe is up; otherwise the bus idles at zero.
  assign rf_wr_data = rf_wr_en ? {{(DATA_W-4){1'b0}}, div_rem} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dst_q      <= '0;
      k          <= '0;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_read <= 1'b0;
      rf_wr_en <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (out_of_range) begin
              err <= 1'b1;
            end else begin
              mem_addr <= base_addr;
              dst_q    <= dst_reg;
              k        <= '0;
              mem_read <= 1'b1;
              busy     <= 1'b1;
              state    <= S_READ;
            end
          end
        end
        S_READ: begin
          state <= S_DIV;
        end
        S_DIV: begin
          if (div_finish) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= dst_q + LAST_OFS - 5'(k);
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          k <= k + KW'(1);
          if (k == KW'(NUM_DIGITS - 1)) begin
            done  <= 1'b1;
            ovf   <= (div_quot != '0);
            state <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nim_digit_splitter.sv
// Directed bench for nim_digit_splitter with a memory and register-file model.
module tb_nim_digit_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [4:0]  dst_reg;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        err;

  logic [31:0] mem  [0:15];
  logic [31:0] regs [0:31];

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;
  int t0e   = 0;

  int          wr_count, done_count, err_count, rd_count;
  int          wr_cyc [0:7];
  logic [4:0]  wr_adr [0:7];
  int          done_cyc;
  logic        done_ovf;
  logic [31:0] rd_addr;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  nim_digit_splitter #(.NUM_DIGITS(6), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .dst_reg    (dst_reg),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) ecnt <= ecnt + 1;

  // Cycle numbering: cycle 1 is the cycle right after the accepting edge t0.
  always @(negedge clk) begin
    if (rf_wr_en) begin
      regs[rf_wr_addr] = rf_wr_data;
      if (wr_count < 8) begin
        wr_cyc[wr_count] = ecnt - t0e + 1;
        wr_adr[wr_count] = rf_wr_addr;
      end
      wr_count++;
    end
    if (done) begin
      done_count++;
      done_cyc = ecnt - t0e + 1;
      done_ovf = ovf;
    end
    if (err) err_count++;
    if (mem_read) begin
      rd_count++;
      rd_addr = mem_addr;
    end
  end

  task automatic clear_logs();
    wr_count = 0; done_count = 0; err_count = 0; rd_count = 0;
    done_cyc = 0; done_ovf = 1'b0; rd_addr = '0;
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 32; i++) regs[i] = SENT;
  endtask

  // Called right after a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [31:0] addr, input logic [4:0] dst);
    base_addr = addr;
    dst_reg   = dst;
    start     = 1'b1;
    t0e       = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_count > 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = 32'h5; dst_reg = 5'd3;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_flags got done=%b ovf=%b err=%b want 000", done, ovf, err); end
    n_cmp++; if (mem_read !== 1'b0 || rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_strobes got rd=%b wr=%b want 00", mem_read, rf_wr_en); end
    n_cmp++; if (mem_addr !== 32'h0 || rf_wr_addr !== 5'h0 || rf_wr_data !== 32'h0) begin n_err++; $display("FAIL reset_buses got %h %h %h want 0 0 0", mem_addr, rf_wr_addr, rf_wr_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_value();
    logic [31:0] exp [0:5] = '{0, 0, 0, 0, 2, 0};
    bit ok;
    mem[0] = 32'd20; clear_regs(); clear_logs();
    launch(32'd0, 5'd20);
    n_cmp++; if (mem_read !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL small_read_cycle got rd=%b busy=%b want 1 1", mem_read, busy); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL small_done_timeout got none want done"); end
    n_cmp++; if (done_cyc !== 200) begin n_err++; $display("FAIL small_done_cycle got %0d want 200", done_cyc); end
    n_cmp++; if (done_ovf !== 1'b0) begin n_err++; $display("FAIL small_ovf got %b want 0", done_ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL small_busy_after got %b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (regs[20+i] !== exp[i]) begin n_err++; $display("FAIL small_reg%0d got %0d want %0d", 20+i, regs[20+i], exp[i]); end
    end
  endtask

  task automatic test_typical_value();
    logic [31:0] exp [0:5] = '{5, 2, 2, 6, 0, 5};
    bit ok;
    mem[0] = 32'd522605; clear_regs(); clear_logs();
    launch(32'd0, 5'd20);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL typ_done_timeout got none want done"); end
    n_cmp++; if (wr_count !== 6) begin n_err++; $display("FAIL typ_write_count got %0d want 6", wr_count); end
    n_cmp++; if (wr_cyc[0] !== 34) begin n_err++; $display("FAIL typ_first_write got cycle %0d want 34", wr_cyc[0]); end
    for (int i = 1; i < 6; i++) begin
      n_cmp++; if (wr_cyc[i] - wr_cyc[i-1] !== 33) begin n_err++; $display("FAIL typ_write_gap%0d got %0d want 33", i, wr_cyc[i] - wr_cyc[i-1]); end
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (wr_adr[i] !== 5'(25 - i)) begin n_err++; $display("FAIL typ_write_order%0d got %0d want %0d", i, wr_adr[i], 25 - i); end
      n_cmp++; if (regs[20+i] !== exp[i]) begin n_err++; $display("FAIL typ_reg%0d got %0d want %0d", 20+i, regs[20+i], exp[i]); end
    end
    n_cmp++; if (rd_count !== 1 || rd_addr !== 32'd0) begin n_err++; $display("FAIL typ_mem_read got n=%0d addr=%0d want 1 0", rd_count, rd_addr); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp [0:5] = '{2, 3, 4, 5, 6, 7};
    bit ok;
    mem[4] = 32'd1234567; clear_regs(); clear_logs();
    launch(32'd4, 5'd8);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_done_timeout got none want done"); end
    n_cmp++; if (done_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", done_ovf); end
    n_cmp++; if (rd_addr !== 32'd4) begin n_err++; $display("FAIL ovf_mem_addr got %0d want 4", rd_addr); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (regs[8+i] !== exp[i]) begin n_err++; $display("FAIL ovf_reg%0d got %0d want %0d", 8+i, regs[8+i], exp[i]); end
    end
  endtask

  task automatic test_zero_top_dst();
    bit ok;
    mem[2] = 32'd0; clear_regs(); clear_logs();
    launch(32'd2, 5'd26);
    wait_done(ok);
    n_cmp++; if (!ok || err_count !== 0) begin n_err++; $display("FAIL zero_accept got done=%0b err=%0d want 1 0", ok, err_count); end
    n_cmp++; if (done_ovf !== 1'b0) begin n_err++; $display("FAIL zero_ovf got %b want 0", done_ovf); end
    for (int i = 26; i < 32; i++) begin
      n_cmp++; if (regs[i] !== 32'd0) begin n_err++; $display("FAIL zero_reg%0d got %h want 0", i, regs[i]); end
    end
  endtask

  task automatic test_max_reg0();
    logic [31:0] exp [0:5] = '{9, 6, 7, 2, 9, 5};
    bit ok;
    mem[7] = 32'hFFFF_FFFF; clear_regs(); clear_logs();
    launch(32'd7, 5'd0);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL max_done_timeout got none want done"); end
    n_cmp++; if (done_ovf !== 1'b1) begin n_err++; $display("FAIL max_ovf got %b want 1", done_ovf); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (regs[i] !== exp[i]) begin n_err++; $display("FAIL max_reg%0d got %0d want %0d", i, regs[i], exp[i]); end
    end
    n_cmp++; if (regs[6] !== SENT) begin n_err++; $display("FAIL max_reg6_untouched got %h want %h", regs[6], SENT); end
  endtask

  task automatic test_reject();
    clear_regs(); clear_logs();
    launch(32'd0, 5'd27);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL rej_err_pulse got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rej_busy got %b want 0", busy); end
    repeat (6) @(negedge clk);
    n_cmp++; if (err_count !== 1) begin n_err++; $display("FAIL rej_err_count got %0d want 1", err_count); end
    n_cmp++; if (rd_count !== 0 || wr_count !== 0) begin n_err++; $display("FAIL rej_no_access got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rej_busy_later got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] exp [0:5] = '{0, 0, 0, 0, 2, 0};
    bit ok;
    bit seen;
    mem[0] = 32'd522605; mem[1] = 32'd20; clear_regs(); clear_logs();
    launch(32'd0, 5'd20);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_count >= 2) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_two_writes got %0d want 2", wr_count); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (150) @(negedge clk);
    n_cmp++; if (wr_count !== 2 || done_count !== 0) begin n_err++; $display("FAIL rstmid_aborted got wr=%0d done=%0d want 2 0", wr_count, done_count); end
    n_cmp++; if (regs[25] !== 32'd5 || regs[24] !== 32'd0 || regs[23] !== SENT) begin n_err++; $display("FAIL rstmid_regs got %h %h %h want 5 0 sentinel", regs[25], regs[24], regs[23]); end
    // Second part: reset, then start on the very next cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_regs(); clear_logs();
    launch(32'd1, 5'd10);
    wait_done(ok);
    n_cmp++; if (!ok || wr_count !== 6) begin n_err++; $display("FAIL rstmid_restart got done=%0b wr=%0d want 1 6", ok, wr_count); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (regs[10+i] !== exp[i]) begin n_err++; $display("FAIL rstmid_reg%0d got %0d want %0d", 10+i, regs[10+i], exp[i]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp [0:5] = '{5, 2, 2, 6, 0, 5};
    bit ok;
    mem[0] = 32'd522605; mem[4] = 32'd1234567; clear_regs(); clear_logs();
    launch(32'd0, 5'd20);
    repeat (50) @(negedge clk);
    base_addr = 32'd4; dst_reg = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    repeat (250) @(negedge clk);
    n_cmp++; if (!ok || done_count !== 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", done_count); end
    n_cmp++; if (wr_count !== 6 || rd_count !== 1) begin n_err++; $display("FAIL ign_access got wr=%0d rd=%0d want 6 1", wr_count, rd_count); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (regs[20+i] !== exp[i]) begin n_err++; $display("FAIL ign_reg%0d got %0d want %0d", 20+i, regs[20+i], exp[i]); end
    end
    n_cmp++; if (regs[0] !== SENT) begin n_err++; $display("FAIL ign_reg0_untouched got %h want %h", regs[0], SENT); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    clear_regs();
    clear_logs();
    test_reset();
    test_small_value();
    test_typical_value();
    test_overflow();
    test_zero_top_dst();
    test_max_reg0();
    test_reject();
    test_reset_mid_run();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
